// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the change sequencer.
// Digit width, radix, FSM states and a digit validity helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_BASE    = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SUB,
    DONE
  } bcd_state_e;

  function automatic logic is_bcd(bcd_digit_t d);
    return d < bcd_digit_t'(BCD_BASE);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtractor with borrow in/out.
// Purely combinational; shared across all digit positions.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t c,
  input  bcd_digit_t p,
  input  logic       b_in,
  output bcd_digit_t d,
  output logic       b_out
);

  logic [4:0] c5;
  logic [4:0] pb5;
  logic [4:0] d5;

  // Subtract in 5 bits, add the radix back when a borrow is needed
  always_comb begin
    c5  = {1'b0, c};
    pb5 = {1'b0, p} + {4'd0, b_in};
    if (c5 >= pb5) begin
      d5    = c5 - pb5;
      b_out = 1'b0;
    end else begin
      d5    = c5 + 5'(BCD_BASE) - pb5;
      b_out = 1'b1;
    end
  end

  assign d = bcd_digit_t'(d5);

endmodule

// File: rtl/bcd_change_ctrl.sv
// Change sequencer: change = credit - price, one BCD digit per clock.
// Optional macro BCD_CHECK_EN adds a non-BCD digit check in CHECK.
module bcd_change_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4*DIGITS-1:0]       credit,
  input  logic [4*DIGITS-1:0]       price,
  output logic                      busy,
  output logic                      done,
  output logic                      insufficient,
  output logic                      invalid_bcd,
  output logic [4*DIGITS-1:0]       change
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  bcd_state_e       state_q, state_d;
  logic [W-1:0]     cred_q, cred_d;
  logic [W-1:0]     price_q, price_d;
  logic [W-1:0]     chg_q, chg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             insuf_q, insuf_d;
  logic             inval_q, inval_d;

  bcd_digit_t       c_dig;
  bcd_digit_t       p_dig;
  bcd_digit_t       d_dig;
  logic             b_out;

  // Select the operand digits at the current index
  always_comb begin
    c_dig = '0;
    p_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        c_dig = cred_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        p_dig = price_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  bcd_digit_sub u_sub (
    .c     (c_dig),
    .p     (p_dig),
    .b_in  (borrow_q),
    .d     (d_dig),
    .b_out (b_out)
  );

`ifdef BCD_CHECK_EN
  logic non_bcd;

  // Any latched digit above 9 marks the operation invalid
  always_comb begin
    non_bcd = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(cred_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          !is_bcd(price_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        non_bcd = 1'b1;
    end
  end
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    cred_d   = cred_q;
    price_d  = price_q;
    chg_d    = chg_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    insuf_d  = insuf_q;
    inval_d  = inval_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cred_d  = credit;
          price_d = price;
          chg_d   = '0;
          insuf_d = 1'b0;
          inval_d = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
`ifdef BCD_CHECK_EN
        if (non_bcd) begin
          inval_d = 1'b1;
          insuf_d = 1'b0;
          chg_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end else
`endif
        if (cred_q < price_q) begin
          insuf_d = 1'b1;
          chg_d   = cred_q;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = SUB;
        end
      end
      SUB: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i))
            chg_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = d_dig;
        end
        borrow_d = b_out;
        if (idx_q == LAST) begin
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cred_q   <= '0;
      price_q  <= '0;
      chg_q    <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      insuf_q  <= 1'b0;
      inval_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cred_q   <= cred_d;
      price_q  <= price_d;
      chg_q    <= chg_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      insuf_q  <= insuf_d;
      inval_q  <= inval_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign insufficient = insuf_q;
  assign change       = chg_q;
`ifdef BCD_CHECK_EN
  assign invalid_bcd  = inval_q;
`else
  assign invalid_bcd  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_change_ctrl.sv
// Testbench for bcd_change_ctrl: decimal reference model plus
// directed literal checks; honours BCD_CHECK_EN like the design.
module tb_bcd_change_ctrl;

  localparam int D = 3;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] credit = '0;
  logic [W-1:0] price = '0;
  logic         busy;
  logic         done;
  logic         insufficient;
  logic         invalid_bcd;
  logic [W-1:0] change;

  int n_cmp = 0;
  int n_fail = 0;

  bcd_change_ctrl #(.DIGITS(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .credit       (credit),
    .price        (price),
    .busy         (busy),
    .done         (done),
    .insufficient (insufficient),
    .invalid_bcd  (invalid_bcd),
    .change       (change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_dec(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Outcome of one accepted operation and its cycles to done
  function automatic void model(input logic [W-1:0] c, input logic [W-1:0] p,
                                output logic [W-1:0] chg, output bit ins,
                                output bit inv, output int lat);
    bit bad = 0;
    int b, x;
    for (int i = 0; i < D; i++)
      if (c[4*i +: 4] > 4'd9 || p[4*i +: 4] > 4'd9) bad = 1;
    chg = '0;
    ins = 0;
    inv = 0;
    lat = 2;
`ifdef BCD_CHECK_EN
    if (bad) begin
      inv = 1;
      return;
    end
`endif
    if (c < p) begin
      ins = 1;
      chg = c;
      return;
    end
    lat = D + 2;
    if (!bad) begin
      chg = to_bcd(to_dec(c) - to_dec(p));
    end else begin
      b = 0;
      for (int i = 0; i < D; i++) begin
        x = int'(c[4*i +: 4]) - int'(p[4*i +: 4]) - b;
        if (x < 0) begin
          x += 10;
          b = 1;
        end else begin
          b = 0;
        end
        chg[4*i +: 4] = x[3:0];
      end
    end
  endfunction

  int           remain = 0;
  logic [W-1:0] m_chg = '0;
  bit           m_ins = 0;
  bit           m_inv = 0;
  logic [W-1:0] p_chg = '0;
  bit           p_ins = 0;
  bit           p_inv = 0;
  int           p_lat = 0;

  // Reference: cycles remaining until idle, results published at done
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain = 0;
      m_chg  = '0;
      m_ins  = 0;
      m_inv  = 0;
    end else if (remain > 0) begin
      remain--;
      if (remain == 1) begin
        m_chg = p_chg;
        m_ins = p_ins;
        m_inv = p_inv;
      end
    end else if (start) begin
      model(credit, price, p_chg, p_ins, p_inv, p_lat);
      remain = p_lat;
      m_chg  = '0;
      m_ins  = 0;
      m_inv  = 0;
    end
  end

  // Compare DUT against the reference every cycle
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(remain > 0));
    chk("done", 32'(done), 32'(remain == 1));
    chk("insufficient", 32'(insufficient), 32'(m_ins));
    chk("invalid_bcd", 32'(invalid_bcd), 32'(m_inv));
    if (remain <= 1) chk("change", 32'(change), 32'(m_chg));
  end

  task automatic op(input string name, input logic [W-1:0] c,
                    input logic [W-1:0] p, input logic [W-1:0] e_chg,
                    input bit e_ins, input bit e_inv, input int e_n);
    int  n = 0;
    bit  got = 0;
    @(posedge clk);
    #1 credit = c;
    price = p;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk({name, "_timeout"}, 32'(got), 32'd1);
    chk({name, "_latency"}, n, e_n);
    chk({name, "_change"}, 32'(change), 32'(e_chg));
    chk({name, "_insuf"}, 32'(insufficient), 32'(e_ins));
    chk({name, "_inval"}, 32'(invalid_bcd), 32'(e_inv));
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk({name, "_timeout"}, 32'(got), 32'd1);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    for (int i = 0; i < D; i++)
      r[4*i +: 4] = ($urandom_range(0, 9) == 0) ?
                    4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    logic [W-1:0] a, b, t;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_change", 32'(change), 32'd0);
    chk("rst_insuf", 32'(insufficient), 32'd0);
    chk("rst_inval", 32'(invalid_bcd), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    op("basic", 12'h500, 12'h235, 12'h265, 0, 0, 4);
    op("ripple", 12'h100, 12'h001, 12'h099, 0, 0, 4);
    op("short", 12'h120, 12'h250, 12'h120, 1, 0, 1);
    op("equal", 12'h345, 12'h345, 12'h000, 0, 0, 4);
`ifdef BCD_CHECK_EN
    op("nonbcd", 12'h1A0, 12'h050, 12'h000, 0, 1, 1);
`else
    op("nonbcd", 12'h1A0, 12'h050, 12'h150, 0, 0, 4);
`endif

    // start held high, operands disturbed after acceptance
    @(posedge clk);
    #1 credit = 12'h500;
    price = 12'h235;
    start = 1'b1;
    @(posedge clk);
    #1 credit = 12'h999;
    price = 12'h000;
    wait_done("held1");
    chk("held1_change", 32'(change), 32'h265);
    @(negedge clk);
    chk("held_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("held2_busy", 32'(busy), 32'd1);
    #1 start = 1'b0;
    wait_done("held2");
    chk("held2_change", 32'(change), 32'h999);

    // reset in the middle of SUB
    @(posedge clk);
    #1 credit = 12'h500;
    price = 12'h235;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_change", 32'(change), 32'd0);
    chk("abort_insuf", 32'(insufficient), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // randomized traffic checked by the reference model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      a = rand_op();
      b = rand_op();
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 1) == 1 && a < b) begin
        t = a;
        a = b;
        b = t;
      end
      credit = a;
      price = b;
      start = ($urandom_range(0, 2) != 0);
    end
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
